// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'd0,
    MODE_DOWN   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [2:0] SEL_MIN = 3'd0;
  localparam logic [2:0] SEL_MAX = 3'd7;

endpackage

// File: rtl/led_seq_tick.sv
// Step prescaler: counts 0..DIV-1 while enabled, holds when disabled,
// and flags the cycle whose clock edge wraps the count back to 0.
module led_seq_tick #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int unsigned W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // Prescaler count; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

  assign wrap = en && (cnt == LAST);

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer for the 3-to-8 decoder: run/pause/stop command FSM with
// walk-up, walk-down, bounce and hold stepping modes.
// Optional feature macro: LED_SEQ_ONESHOT_EN (single sweep, then IDLE).
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 12000000,
  parameter int unsigned STEP_HZ = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  output logic [2:0] sel,
  output logic       en,
  output logic       step,
  output logic       busy
);

  localparam int unsigned DIV = CLK_HZ / STEP_HZ;

  if (DIV < 2) begin : g_bad_div
    $error("led_seq_ctrl: CLK_HZ/STEP_HZ must be at least 2");
  end

`ifdef LED_SEQ_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  state_t     state, state_d;
  mode_t      mode_in, prev_mode, prev_mode_d;
  logic [2:0] sel_d;
  logic       dir_up, dir_up_d;
  logic       swept, swept_d;
  logic       step_d;
  logic       wrap;
  logic       tick_en;
  logic       tick_clr;

  assign mode_in  = mode_t'(mode);
  // A stop on a wrap edge freezes the prescaler, which also suppresses the wrap.
  assign tick_en  = (state == ST_RUN) && !stop;
  assign tick_clr = (state == ST_IDLE);

  led_seq_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (tick_en),
    .clr (tick_clr),
    .wrap(wrap)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      sel       <= SEL_MIN;
      en        <= 1'b0;
      busy      <= 1'b0;
      step      <= 1'b0;
      dir_up    <= 1'b1;
      swept     <= 1'b0;
      prev_mode <= MODE_UP;
    end else begin
      state     <= state_d;
      sel       <= sel_d;
      en        <= (state_d != ST_IDLE);
      busy      <= (state_d != ST_IDLE);
      step      <= step_d;
      dir_up    <= dir_up_d;
      swept     <= swept_d;
      prev_mode <= prev_mode_d;
    end
  end

  // Next-state, index advance and bounce direction tracking.
  always_comb begin
    logic       dir_now;
    logic       finish;
    logic [2:0] nxt;
    state_d     = state;
    sel_d       = sel;
    dir_up_d    = dir_up;
    swept_d     = swept;
    prev_mode_d = prev_mode;
    step_d      = 1'b0;
    dir_now     = dir_up;
    finish      = 1'b0;
    nxt         = sel;
    case (state)
      ST_IDLE: begin
        sel_d = SEL_MIN;
        if (start && !stop) begin
          state_d     = ST_RUN;
          sel_d       = (mode_in == MODE_DOWN) ? SEL_MAX : SEL_MIN;
          dir_up_d    = 1'b1;
          swept_d     = 1'b0;
          prev_mode_d = mode_in;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_PAUSE;
        end else if (wrap) begin
          step_d      = 1'b1;
          prev_mode_d = mode_in;
          case (mode_in)
            MODE_UP: begin
              if (ONESHOT && sel == SEL_MAX) finish = 1'b1;
              else sel_d = sel + 3'd1;
            end
            MODE_DOWN: begin
              if (ONESHOT && sel == SEL_MIN) finish = 1'b1;
              else sel_d = sel - 3'd1;
            end
            MODE_BOUNCE: begin
              // Switching into bounce picks a direction from the current index
              // instead of reusing a stale one from an earlier bounce run.
              dir_now = (prev_mode == MODE_BOUNCE) ? dir_up : (sel != SEL_MAX);
              if (ONESHOT && swept && sel == SEL_MIN) begin
                finish = 1'b1;
              end else begin
                nxt      = dir_now ? sel + 3'd1 : sel - 3'd1;
                sel_d    = nxt;
                dir_up_d = dir_now;
                if (nxt == SEL_MAX) begin
                  dir_up_d = 1'b0;
                  swept_d  = 1'b1;
                end else if (nxt == SEL_MIN) begin
                  dir_up_d = 1'b1;
                end
              end
            end
            default: ; // hold: index unchanged, step still pulses
          endcase
          if (finish) begin
            state_d = ST_IDLE;
            sel_d   = SEL_MIN;
            step_d  = 1'b0;
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
          sel_d   = SEL_MIN;
        end else if (start) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = SEL_MIN;
      end
    endcase
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed self-checking bench for led_seq_ctrl with DIV = 4.
// Covers both builds of LED_SEQ_ONESHOT_EN.
module tb_led_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [2:0] sel;
  logic       en;
  logic       step;
  logic       busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  led_seq_ctrl #(
    .CLK_HZ (8),
    .STEP_HZ(2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .stop (stop),
    .mode (mode),
    .sel  (sel),
    .en   (en),
    .step (step),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; inputs are driven and outputs sampled 1 time unit later.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] s, input logic e,
                         input logic b, input logic st);
    chk({tag, ".sel"}, {5'd0, sel}, {5'd0, s});
    chk({tag, ".en"}, {7'd0, en}, {7'd0, e});
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, b});
    chk({tag, ".step"}, {7'd0, step}, {7'd0, st});
  endtask

  logic [2:0] exp_sel;
  logic [2:0] bounce_exp [16];
  logic [2:0] hold_sel;

  initial begin
    bounce_exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
                   3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
    rst = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0;

    // Power-on reset
    cyc(3);
    rst = 1'b1;
    chk_out("reset0", 3'd0, 1'b0, 1'b0, 1'b0);

    // Walk up: start visible after the sampling edge, advance every 4 edges
    mode = 2'd0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk_out("up_start", 3'd0, 1'b1, 1'b1, 1'b0);
    exp_sel = 3'd0;
    for (int i = 0; i < 7; i++) begin
      cyc(3);
      chk_out("up_wait", exp_sel, 1'b1, 1'b1, 1'b0);
      cyc(1);
      exp_sel = exp_sel + 3'd1;
      chk_out("up_adv", exp_sel, 1'b1, 1'b1, 1'b1);
    end
    cyc(4);
`ifdef LED_SEQ_ONESHOT_EN
    chk_out("up_oneshot_end", 3'd0, 1'b0, 1'b0, 1'b0);
`else
    chk_out("up_wrap", 3'd0, 1'b1, 1'b1, 1'b1);
`endif

    // Stop held two cycles: RUN -> PAUSE -> IDLE
    stop = 1'b1;
    cyc(2);
    stop = 1'b0;
    chk_out("to_idle", 3'd0, 1'b0, 1'b0, 1'b0);

    // Bounce
    mode = 2'd2; start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk_out("bnc_start", 3'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) begin
      cyc(4);
      chk_out("bnc_adv", bounce_exp[i], 1'b1, 1'b1, 1'b1);
    end
`ifdef LED_SEQ_ONESHOT_EN
    cyc(4);
    chk_out("bnc_oneshot_end", 3'd0, 1'b0, 1'b0, 1'b0);
    mode = 2'd2; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(8);
    chk_out("bnc_restart", 3'd2, 1'b1, 1'b1, 1'b1);
`else
    for (int i = 14; i < 16; i++) begin
      cyc(4);
      chk_out("bnc_adv", bounce_exp[i], 1'b1, 1'b1, 1'b1);
    end
`endif

    // Reset held 3 cycles mid-RUN (sel = 2)
    cyc(2);
    rst = 1'b0;
    cyc(3);
    rst = 1'b1;
    chk_out("reset_run", 3'd0, 1'b0, 1'b0, 1'b0);

    // Pause: stop sampled 3 edges after an advance, so 2 prescaler counts done
    mode = 2'd0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(4);
    chk_out("pause_adv", 3'd1, 1'b1, 1'b1, 1'b1);
    cyc(2);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk_out("pause_enter", 3'd1, 1'b1, 1'b1, 1'b0);
    cyc(10);
    chk_out("pause_hold", 3'd1, 1'b1, 1'b1, 1'b0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk_out("resume", 3'd1, 1'b1, 1'b1, 1'b0);
    cyc(1);
    chk_out("resume_wait", 3'd1, 1'b1, 1'b1, 1'b0);
    cyc(1);
    chk_out("resume_adv", 3'd2, 1'b1, 1'b1, 1'b1);
    stop = 1'b1;
    cyc(1);
    chk_out("pause2", 3'd2, 1'b1, 1'b1, 1'b0);
    cyc(1);
    stop = 1'b0;
    chk_out("pause_to_idle", 3'd0, 1'b0, 1'b0, 1'b0);

    // Simultaneous start/stop in IDLE: stays IDLE
    start = 1'b1; stop = 1'b1;
    cyc(2);
    start = 1'b0; stop = 1'b0;
    chk_out("both_idle", 3'd0, 1'b0, 1'b0, 1'b0);

    // Simultaneous start/stop on a wrap edge in RUN: PAUSE, no step
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    chk_out("both_wrap", 3'd0, 1'b1, 1'b1, 1'b0);
    // Prescaler froze at its last count, so the advance follows resume at once
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk_out("both_resume", 3'd0, 1'b1, 1'b1, 1'b0);
    cyc(1);
    chk_out("both_adv", 3'd1, 1'b1, 1'b1, 1'b1);
    stop = 1'b1;
    cyc(2);
    stop = 1'b0;

    // Walk down (one sweep in the oneshot build)
    mode = 2'd1; start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk_out("dn_start", 3'd7, 1'b1, 1'b1, 1'b0);
    exp_sel = 3'd7;
    for (int i = 0; i < 7; i++) begin
      cyc(4);
      exp_sel = exp_sel - 3'd1;
      chk_out("dn_adv", exp_sel, 1'b1, 1'b1, 1'b1);
    end
    cyc(4);
`ifdef LED_SEQ_ONESHOT_EN
    chk_out("dn_oneshot_end", 3'd0, 1'b0, 1'b0, 1'b0);
    mode = 2'd3; start = 1'b1;
    cyc(1);
    start = 1'b0;
    hold_sel = 3'd0;
`else
    chk_out("dn_wrap", 3'd7, 1'b1, 1'b1, 1'b1);
    hold_sel = 3'd7;
`endif

    // Hold: mode change during RUN, step pulses with sel unchanged
    mode = 2'd3;
    cyc(4);
    chk_out("hold_adv", hold_sel, 1'b1, 1'b1, 1'b1);
    cyc(4);
    chk_out("hold_adv2", hold_sel, 1'b1, 1'b1, 1'b1);

    // Switching into bounce: at 7 it heads down, otherwise up
    mode = 2'd2;
    cyc(4);
`ifdef LED_SEQ_ONESHOT_EN
    chk_out("bnc_entry", 3'd1, 1'b1, 1'b1, 1'b1);
`else
    chk_out("bnc_entry", 3'd6, 1'b1, 1'b1, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
